// File: rtl/core_decode_iq_pkg.sv
// core_decode_iq_pkg: RV32 decode types, micro-op layout and ALU op helper
// Contents: regaddr_t, aluop_t, wsel_t, dec_t (decoder output), uop_t (issue-queue entry)
package core_decode_iq_pkg;
    localparam int RV_XLEN = 32;
    typedef logic [4:0] regaddr_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } aluop_t;
    typedef enum logic [1:0] {WSEL_ALU, WSEL_MEM, WSEL_PC4, WSEL_CSR} wsel_t;
    typedef struct packed {
        regaddr_t rs1;
        regaddr_t rs2;
        regaddr_t rd;
        logic [RV_XLEN-1:0] imm;
        logic [11:0] csr_addr;
        logic reg_wen;
        wsel_t reg_wsel;
        aluop_t aluop;
        logic asel;
        logic bsel;
        logic [2:0] mem_type;
        logic mem_ren;
        logic mem_wen;
        logic is_jump;
        logic is_branch;
        logic [2:0] branch_cond;
    } dec_t;
    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] imm;
        logic [RV_XLEN-1:0] rs1_val;
        logic [RV_XLEN-1:0] rs2_val;
        regaddr_t rs1;
        regaddr_t rs2;
        regaddr_t rd;
        logic reg_wen;
        wsel_t reg_wsel;
        aluop_t aluop;
        logic asel;
        logic bsel;
        logic [2:0] mem_type;
        logic mem_ren;
        logic mem_wen;
        logic is_jump;
        logic is_branch;
        logic [2:0] branch_cond;
        logic predicted_taken;
        logic [RV_XLEN-1:0] csr_value;
    } uop_t;
    function automatic aluop_t alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return alt ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/core_decode_iq_if.sv
// core_decode_iq_if: issue handshake between the decode queue and execute
// Signals: x_valid (head issuable), x_ready (execute accepts), x_uop (head micro-op)
interface core_decode_iq_if;
    import core_decode_iq_pkg::*;
    logic x_valid;
    logic x_ready;
    uop_t x_uop;
    modport master(output x_valid, output x_uop, input x_ready);
    modport slave(input x_valid, input x_uop, output x_ready);
endinterface

// File: rtl/core_decode_iq_decoder.sv
// core_decode_iq_decoder: combinational RV32I/Zicsr instruction decoder
// Ports: i_ir instruction word in; o_dec decoded fields out
// Sources an instruction does not read are reported as x0 so they never wait on a hazard.
module core_decode_iq_decoder
    import core_decode_iq_pkg::*;
(
    input  logic [RV_XLEN-1:0] i_ir,
    output dec_t               o_dec
);
    logic [2:0] w_f3;
    logic [RV_XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    assign w_f3    = i_ir[14:12];
    assign w_imm_i = {{20{i_ir[31]}}, i_ir[31:20]};
    assign w_imm_s = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
    assign w_imm_b = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
    assign w_imm_u = {i_ir[31:12], 12'd0};
    assign w_imm_j = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
    always_comb begin
        o_dec = '0;
        o_dec.rd = i_ir[11:7];
        o_dec.csr_addr = i_ir[31:20];
        o_dec.mem_type = w_f3;
        o_dec.branch_cond = w_f3;
        case (i_ir[6:0])
            7'b0110111: begin
                o_dec.reg_wen = 1'b1; o_dec.aluop = ALU_PASSB; o_dec.bsel = 1'b1; o_dec.imm = w_imm_u;
            end
            7'b0010111: begin
                o_dec.reg_wen = 1'b1; o_dec.asel = 1'b1; o_dec.bsel = 1'b1; o_dec.imm = w_imm_u;
            end
            7'b1101111: begin
                o_dec.reg_wen = 1'b1; o_dec.reg_wsel = WSEL_PC4; o_dec.is_jump = 1'b1;
                o_dec.asel = 1'b1; o_dec.bsel = 1'b1; o_dec.imm = w_imm_j;
            end
            7'b1100111: begin
                o_dec.rs1 = i_ir[19:15]; o_dec.reg_wen = 1'b1; o_dec.reg_wsel = WSEL_PC4;
                o_dec.is_jump = 1'b1; o_dec.bsel = 1'b1; o_dec.imm = w_imm_i;
            end
            7'b1100011: begin
                o_dec.rs1 = i_ir[19:15]; o_dec.rs2 = i_ir[24:20]; o_dec.is_branch = 1'b1;
                o_dec.aluop = ALU_SUB; o_dec.imm = w_imm_b;
            end
            7'b0000011: begin
                o_dec.rs1 = i_ir[19:15]; o_dec.reg_wen = 1'b1; o_dec.reg_wsel = WSEL_MEM;
                o_dec.mem_ren = 1'b1; o_dec.bsel = 1'b1; o_dec.imm = w_imm_i;
            end
            7'b0100011: begin
                o_dec.rs1 = i_ir[19:15]; o_dec.rs2 = i_ir[24:20]; o_dec.mem_wen = 1'b1;
                o_dec.bsel = 1'b1; o_dec.imm = w_imm_s;
            end
            7'b0010011: begin
                o_dec.rs1 = i_ir[19:15]; o_dec.reg_wen = 1'b1; o_dec.bsel = 1'b1; o_dec.imm = w_imm_i;
                o_dec.aluop = alu_op(w_f3, (w_f3 == 3'd5) & i_ir[30]);
            end
            7'b0110011: begin
                o_dec.rs1 = i_ir[19:15]; o_dec.rs2 = i_ir[24:20]; o_dec.reg_wen = 1'b1;
                o_dec.aluop = alu_op(w_f3, i_ir[30]);
            end
            7'b1110011: begin
                // CSR immediate forms carry a zimm in the rs1 field, not a register
                o_dec.rs1 = w_f3[2] ? 5'd0 : i_ir[19:15];
                o_dec.reg_wen = w_f3 != 3'd0; o_dec.reg_wsel = WSEL_CSR;
                o_dec.imm = {27'd0, i_ir[19:15]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/core_decode_iq.sv
// core_decode_iq: decode stage feeding a DEPTH-entry in-order issue queue with writeback wakeup
// Ports: clk/rst; fetch side d_*; register file rf_*; forwarding d_fwd_*; hazard pend d_rs*_pend;
//        writeback snoop wb_*; issue handshake x_if (x_valid/x_ready/x_uop); occupancy count
// Option: CORE_DECODE_WB_BYPASS_EN lets a head waiting only on the current writeback issue the same cycle.
module core_decode_iq
    import core_decode_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       d_valid,
    output logic                       d_ready,
    input  logic [XLEN-1:0]            d_ir,
    input  logic [XLEN-1:0]            d_pc,
    input  logic [XLEN-1:0]            d_csr_value,
    input  logic                       d_predicted_taken,
    input  logic                       d_flush,
    input  logic                       d_stall,
    output regaddr_t                   d_rs1,
    output regaddr_t                   d_rs2,
    output logic [XLEN-1:0]            d_imm,
    output logic [11:0]                d_csr_addr,
    output logic                       d_is_branch,
    output regaddr_t                   rf_raddr1,
    output regaddr_t                   rf_raddr2,
    input  logic [XLEN-1:0]            rf_rdata1,
    input  logic [XLEN-1:0]            rf_rdata2,
    input  logic                       d_fwd_rs1en,
    input  logic                       d_fwd_rs2en,
    input  logic [XLEN-1:0]            d_fwd_value1,
    input  logic [XLEN-1:0]            d_fwd_value2,
    input  logic                       d_rs1_pend,
    input  logic                       d_rs2_pend,
    input  logic                       wb_en,
    input  regaddr_t                   wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    core_decode_iq_if.master           x_if,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    dec_t w_dec;
    uop_t w_new, w_head;
    uop_t r_uop [DEPTH];
    logic [DEPTH-1:0] r_valid, r_rdy1, r_rdy2;
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic w_full, w_enq, w_deq, w_wb, w_hit1, w_hit2, w_rdy1, w_rdy2;
    logic [XLEN-1:0] w_v1, w_v2;
    core_decode_iq_decoder u_dec (.i_ir(d_ir), .o_dec(w_dec));
    assign d_rs1       = w_dec.rs1;
    assign d_rs2       = w_dec.rs2;
    assign rf_raddr1   = w_dec.rs1;
    assign rf_raddr2   = w_dec.rs2;
    assign d_imm       = w_dec.imm;
    assign d_csr_addr  = w_dec.csr_addr;
    assign d_is_branch = w_dec.is_branch;
    assign count       = r_count;
    // Full blocks enqueue even when the head leaves this cycle, keeping d_ready off the x_ready path
    assign w_full  = r_count == CW'(DEPTH);
    assign d_ready = d_flush | (~d_stall & ~w_full);
    assign w_enq   = d_valid & ~d_flush & ~d_stall & ~w_full;
    assign w_deq   = x_if.x_valid & x_if.x_ready;
    assign w_wb    = wb_en & (wb_rd != '0);
    assign w_hit1  = w_wb & (wb_rd == w_dec.rs1);
    assign w_hit2  = w_wb & (wb_rd == w_dec.rs2);
    assign w_v1    = d_fwd_rs1en ? d_fwd_value1 : rf_rdata1;
    assign w_v2    = d_fwd_rs2en ? d_fwd_value2 : rf_rdata2;
    assign w_rdy1  = (w_dec.rs1 == '0) | ~d_rs1_pend | w_hit1;
    assign w_rdy2  = (w_dec.rs2 == '0) | ~d_rs2_pend | w_hit2;
    always_comb begin
        w_new = '0;
        w_new.pc = d_pc;
        w_new.imm = w_dec.imm;
        w_new.rs1_val = (d_rs1_pend & w_hit1) ? wb_data : w_v1;
        w_new.rs2_val = (d_rs2_pend & w_hit2) ? wb_data : w_v2;
        w_new.rs1 = w_dec.rs1;
        w_new.rs2 = w_dec.rs2;
        w_new.rd = w_dec.rd;
        w_new.reg_wen = w_dec.reg_wen;
        w_new.reg_wsel = w_dec.reg_wsel;
        w_new.aluop = w_dec.aluop;
        w_new.asel = w_dec.asel;
        w_new.bsel = w_dec.bsel;
        w_new.mem_type = w_dec.mem_type;
        w_new.mem_ren = w_dec.mem_ren;
        w_new.mem_wen = w_dec.mem_wen;
        w_new.is_jump = w_dec.is_jump;
        w_new.is_branch = w_dec.is_branch;
        w_new.branch_cond = w_dec.branch_cond;
        w_new.predicted_taken = d_predicted_taken;
        w_new.csr_value = d_csr_value;
    end
    always_ff @(posedge clk) begin
        if (rst | d_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] & ~r_rdy1[i] & w_wb & (r_uop[i].rs1 == wb_rd)) begin
                    r_uop[i].rs1_val <= wb_data;
                    r_rdy1[i] <= 1'b1;
                end
                if (r_valid[i] & ~r_rdy2[i] & w_wb & (r_uop[i].rs2 == wb_rd)) begin
                    r_uop[i].rs2_val <= wb_data;
                    r_rdy2[i] <= 1'b1;
                end
            end
            if (w_enq) begin
                r_uop[r_tail] <= w_new;
                r_valid[r_tail] <= 1'b1;
                r_rdy1[r_tail] <= w_rdy1;
                r_rdy2[r_tail] <= w_rdy2;
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end
    assign w_head = r_uop[r_head];
`ifdef CORE_DECODE_WB_BYPASS_EN
    logic w_bp1, w_bp2;
    assign w_bp1 = ~r_rdy1[r_head] & w_wb & (w_head.rs1 == wb_rd);
    assign w_bp2 = ~r_rdy2[r_head] & w_wb & (w_head.rs2 == wb_rd);
    assign x_if.x_valid = (r_count != '0) & (r_rdy1[r_head] | w_bp1) & (r_rdy2[r_head] | w_bp2);
    always_comb begin
        x_if.x_uop = w_head;
        x_if.x_uop.rs1_val = w_bp1 ? wb_data : w_head.rs1_val;
        x_if.x_uop.rs2_val = w_bp2 ? wb_data : w_head.rs2_val;
    end
`else
    assign x_if.x_valid = (r_count != '0) & r_rdy1[r_head] & r_rdy2[r_head];
    assign x_if.x_uop = w_head;
`endif
endmodule

// File: tb/tb_core_decode_iq.sv
// tb_core_decode_iq: scoreboard bench for the decode issue queue
module tb_core_decode_iq;
    import core_decode_iq_pkg::*;
`ifdef CORE_DECODE_WB_BYPASS_EN
    localparam logic BP = 1'b1;
`else
    localparam logic BP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic d_valid, d_ready, d_predicted_taken, d_flush, d_stall, d_is_branch;
    logic [31:0] d_ir, d_pc, d_csr_value, d_imm, rf_rdata1, rf_rdata2, d_fwd_value1, d_fwd_value2, wb_data;
    regaddr_t d_rs1, d_rs2, rf_raddr1, rf_raddr2, wb_rd;
    logic [11:0] d_csr_addr;
    logic d_fwd_rs1en, d_fwd_rs2en, d_rs1_pend, d_rs2_pend, wb_en;
    logic [2:0] count;
    core_decode_iq_if x_if ();
    core_decode_iq #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_ready(d_ready), .d_ir(d_ir), .d_pc(d_pc),
        .d_csr_value(d_csr_value), .d_predicted_taken(d_predicted_taken), .d_flush(d_flush),
        .d_stall(d_stall), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_imm(d_imm), .d_csr_addr(d_csr_addr),
        .d_is_branch(d_is_branch), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .d_fwd_rs1en(d_fwd_rs1en),
        .d_fwd_rs2en(d_fwd_rs2en), .d_fwd_value1(d_fwd_value1), .d_fwd_value2(d_fwd_value2),
        .d_rs1_pend(d_rs1_pend), .d_rs2_pend(d_rs2_pend), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .x_if(x_if), .count(count)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;
    exp_t sb [$];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic neg;
        @(negedge clk);
    endtask
    function automatic logic [31:0] op_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction
    task automatic drive(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] r1, input logic [31:0] r2);
        d_valid = 1'b1;
        d_pc = pc;
        d_ir = ir;
        rf_rdata1 = r1;
        rf_rdata2 = r2;
    endtask
    task automatic push(input logic [31:0] pc, input logic [31:0] v1, input logic [31:0] v2);
        exp_t e;
        e.pc = pc;
        e.v1 = v1;
        e.v2 = v2;
        sb.push_back(e);
    endtask
    always @(negedge clk) begin
        if (!rst && !d_flush && x_if.x_valid && x_if.x_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("uop_pc", x_if.x_uop.pc, e.pc);
                chk("uop_rs1", x_if.x_uop.rs1_val, e.v1);
                chk("uop_rs2", x_if.x_uop.rs2_val, e.v2);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end
    initial begin
        d_valid = 0; d_ir = 0; d_pc = 0; d_csr_value = 0; d_predicted_taken = 0; d_flush = 0; d_stall = 0;
        rf_rdata1 = 0; rf_rdata2 = 0; d_fwd_rs1en = 0; d_fwd_rs2en = 0; d_fwd_value1 = 0; d_fwd_value2 = 0;
        d_rs1_pend = 0; d_rs2_pend = 0; wb_en = 0; wb_rd = 0; wb_data = 0; x_if.x_ready = 0;
        repeat (2) step;
        rst = 0;
        neg;
        chk("rst_count", count, 0);
        chk("rst_xvalid", x_if.x_valid, 0);
        chk("rst_dready", d_ready, 1);
        step;
        x_if.x_ready = 1;
        drive(32'h100, op_add(3, 1, 2), 32'h1234, 32'h5678);
        neg;
        chk("t1_dready", d_ready, 1);
        chk("t1_raddr1", rf_raddr1, 1);
        push(32'h100, 32'h1234, 32'h5678);
        step;
        d_valid = 0;
        neg;
        chk("t1_xvalid", x_if.x_valid, 1);
        chk("t1_count", count, 1);
        step;
        neg;
        chk("t1_drain_count", count, 0);
        chk("t1_drain_xvalid", x_if.x_valid, 0);
        step;
        x_if.x_ready = 0;
        for (int i = 0; i < 5; i++) begin
            drive(32'h200 + 32'(4 * i), op_add(3, 1, 2), 32'h10 + 32'(i), 32'h0);
            neg;
            chk("t2_dready", d_ready, (i < 4) ? 1 : 0);
            if (i < 4) push(32'h200 + 32'(4 * i), 32'h10 + 32'(i), 32'h0);
            step;
        end
        neg;
        chk("t2_full_count", count, 4);
        chk("t2_full_xvalid", x_if.x_valid, 1);
        step;
        x_if.x_ready = 1;
        neg;
        chk("t2_full_deq_dready", d_ready, 0);
        step;
        x_if.x_ready = 0;
        neg;
        chk("t2_freed_count", count, 3);
        chk("t2_freed_dready", d_ready, 1);
        push(32'h210, 32'h14, 32'h0);
        step;
        d_valid = 0;
        neg;
        chk("t2_refill_count", count, 4);
        step;
        x_if.x_ready = 1;
        repeat (4) begin
            neg;
            step;
        end
        neg;
        chk("t2_drained", count, 0);
        step;
        drive(32'h300, op_add(6, 5, 2), 32'hBAD, 32'h22);
        d_rs1_pend = 1;
        neg;
        push(32'h300, 32'hDEAD, 32'h22);
        step;
        d_valid = 0;
        d_rs1_pend = 0;
        neg;
        chk("t3_wait", x_if.x_valid, 0);
        step;
        wb_en = 1; wb_rd = 0; wb_data = 32'hDEAD;
        neg;
        chk("t3_wb_x0", x_if.x_valid, 0);
        step;
        wb_rd = 6;
        neg;
        chk("t3_wb_other", x_if.x_valid, 0);
        step;
        wb_rd = 5;
        neg;
        chk("t3_wake_same", x_if.x_valid, BP);
        step;
        wb_en = 0;
        neg;
        chk("t3_wake_next", x_if.x_valid, !BP);
        chk("t3_count", count, BP ? 0 : 1);
        step;
        neg;
        chk("t3_drained", count, 0);
        step;
        drive(32'h400, op_add(8, 7, 2), 32'hBAD, 32'h33);
        d_rs1_pend = 1; wb_en = 1; wb_rd = 7; wb_data = 32'h42; d_fwd_rs2en = 1; d_fwd_value2 = 32'hF00D;
        neg;
        push(32'h400, 32'h42, 32'hF00D);
        step;
        d_valid = 0; d_rs1_pend = 0; wb_en = 0; d_fwd_rs2en = 0;
        neg;
        chk("t4_capture_xvalid", x_if.x_valid, 1);
        step;
        drive(32'h440, op_add(4, 0, 2), 32'h0, 32'h44);
        d_rs1_pend = 1;
        neg;
        push(32'h440, 32'h0, 32'h44);
        step;
        d_valid = 0; d_rs1_pend = 0;
        neg;
        chk("t4_x0_xvalid", x_if.x_valid, 1);
        step;
        x_if.x_ready = 0;
        drive(32'h500, op_add(1, 1, 2), 32'h51, 32'h52);
        neg;
        push(32'h500, 32'h51, 32'h52);
        step;
        drive(32'h504, op_add(10, 9, 2), 32'hBAD, 32'h53);
        d_rs1_pend = 1;
        neg;
        push(32'h504, 32'h99, 32'h53);
        step;
        d_valid = 0; d_rs1_pend = 0; x_if.x_ready = 1; wb_en = 1; wb_rd = 9; wb_data = 32'h99;
        neg;
        step;
        wb_en = 0;
        neg;
        chk("t5_nonhead_xvalid", x_if.x_valid, 1);
        step;
        neg;
        chk("t5_drained", count, 0);
        step;
        x_if.x_ready = 0;
        drive(32'h600, op_add(3, 1, 2), 32'h60, 32'h61);
        d_stall = 1;
        neg;
        chk("t6_stall_dready", d_ready, 0);
        step;
        neg;
        chk("t6_stall_count", count, 0);
        step;
        d_stall = 0;
        neg;
        push(32'h600, 32'h60, 32'h61);
        step;
        for (int i = 1; i < 3; i++) begin
            drive(32'h600 + 32'(4 * i), op_add(3, 1, 2), 32'h60, 32'h61);
            neg;
            push(32'h600 + 32'(4 * i), 32'h60, 32'h61);
            step;
        end
        d_flush = 1; x_if.x_ready = 1;
        drive(32'h60C, op_add(3, 1, 2), 32'h60, 32'h61);
        neg;
        chk("t7_flush_dready", d_ready, 1);
        step;
        sb.delete();
        d_flush = 0; d_valid = 0;
        neg;
        chk("t7_flush_count", count, 0);
        chk("t7_flush_xvalid", x_if.x_valid, 0);
        step;
        x_if.x_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h700 + 32'(4 * i), op_add(3, 1, 2), 32'h70, 32'h71);
            neg;
            push(32'h700 + 32'(4 * i), 32'h70, 32'h71);
            step;
        end
        d_valid = 0;
        neg;
        chk("t8_full_count", count, 4);
        step;
        rst = 1;
        d_valid = 1;
        neg;
        step;
        rst = 0;
        d_valid = 0;
        sb.delete();
        neg;
        chk("t8_rst_count", count, 0);
        chk("t8_rst_xvalid", x_if.x_valid, 0);
        chk("t8_rst_dready", d_ready, 1);
        step;
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_decode_iq.md
# core_decode_iq

Decode stage with a parametrised in-order issue queue between decode and execute. Each valid fetch instruction is decoded, its operands resolved from the register file or forwarding, and a micro-op enqueued into a DEPTH-entry FIFO. The FIFO head issues to execute when both operands are ready. Operands still in flight are captured later from a writeback snoop port, so decode no longer stalls on every non-forwardable hazard.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, 2..8
- XLEN, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- d_valid  in  1  fetch instruction valid
- d_ready  out  1  decode accepts
- d_ir, d_pc, d_csr_value  in  XLEN  instruction, pc, csr read value
- d_predicted_taken  in  1  branch prediction
- d_flush, d_stall  in  1  hazard-unit flush / stall
- d_rs1, d_rs2  out  5  decoded sources (rv::regaddr_t)
- d_imm  out  XLEN  decoded immediate
- d_csr_addr  out  12  decoded CSR address
- d_is_branch  out  1  decoded branch flag
- rf_raddr1, rf_raddr2  out  5  register-file read addresses
- rf_rdata1, rf_rdata2  in  XLEN  register-file data
- d_fwd_rs1en, d_fwd_rs2en  in  1  forward select
- d_fwd_value1, d_fwd_value2  in  XLEN  forward data
- d_rs1_pend, d_rs2_pend  in  1  producer in flight, value not yet available
- wb_en  in  1  writeback valid
- wb_rd  in  5  writeback register
- wb_data  in  XLEN  writeback value
- x_valid  out  1  head micro-op issuable
- x_ready  in  1  execute accepts
- x_uop  out  uop_t  head micro-op
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- d_ready = d_flush | (~d_stall & ~full). Full blocks enqueue even if the head dequeues the same cycle.
- Enqueue = d_valid & d_ready & ~d_flush & ~d_stall. The entry is written at the tail: decoded fields, pc, csr_value, predicted_taken, operands and per-operand ready bits.
- Operand value = fwd_value if fwd_en, else rf_rdata.
- Ready bit = ~pend. A source of x0 is always ready.
- Enqueue-time capture: if the operand is pending and wb_en & wb_rd == rs & rs != 0, the entry stores wb_data and marks the operand ready.
- Wakeup: each cycle, every valid entry whose operand is not ready and whose rs matches wb_rd (wb_en, wb_rd != 0) captures wb_data and marks the operand ready.
- x_valid = (count != 0) & head rs1_ready & head rs2_ready. Dequeue = x_valid & x_ready.
- Pointers wrap modulo DEPTH. count increments on enqueue only, decrements on dequeue only, and is unchanged on both.
- Flush: next edge sets count = 0, clears all entries and resets head = tail = 0. Flush dominates any same-cycle enqueue, dequeue or wakeup.
- Reset: count 0, pointers 0, all entry valid/ready bits 0, x_valid 0, d_ready reflects empty.

## Timing
- Enqueue at edge N: x_valid is high during cycle N+1 if both operands are ready.
- A pending operand woken at edge N makes the head issuable in cycle N+1.
- x_uop is driven from entry storage (registered); the bypass path below adds a mux only.
- Dequeue and wakeup of a non-head entry in the same cycle are independent.

## Configuration
- CORE_DECODE_WB_BYPASS_EN defined: a head with exactly its missing operands matched by the current wb port raises x_valid in the same cycle. x_uop carries wb_data for those operands. Storage still updates at the edge.
- CORE_DECODE_WB_BYPASS_EN undefined: the head issues one cycle after wakeup. No combinational path from wb_* to x_*.

## Structure
- uop_t (packed: pc, imm, rs1/rs2 values and indices, rd, reg_wen, reg_wsel, aluop, asel, bsel, mem_type, mem_ren, mem_wen, is_jump, is_branch, branch_cond, predicted_taken, csr_value) goes in the rv package beside dec_t.
- Instantiates the existing core_decoder. Queue storage, pointers and wakeup logic live in this module; no further sub-module.

## Test plan
- Empty queue, ALU op with ready operands, x_ready=1 -> x_valid in cycle after enqueue, x_uop.rs1 = rf_rdata1 (0x1234), count returns to 0.
- x_ready=0, DEPTH=4, five back-to-back instructions -> count=4, d_ready=0 on fifth, fifth held until a dequeue frees a slot.
- Enqueue with d_rs1_pend=1 (rs1=x5) and wb later writes x5=0xDEAD -> x_valid low until wakeup, then x_uop.rs1=0xDEAD (same cycle with CORE_DECODE_WB_BYPASS_EN, next cycle without).
- Enqueue pending x7 in the same cycle wb writes x7=0x42 -> entry ready immediately, issues next cycle with 0x42. wb_rd=0 never wakes anything.
- Three entries queued, d_flush with simultaneous d_valid and x_ready -> next cycle count=0, x_valid=0, no issue or enqueue.
- rst asserted mid-operation with full queue -> next cycle count=0, x_valid=0, d_ready=1.
